// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART blocks: parity modes, receiver
// FSM encoding and the oversample divider calculation.
package uart_pkg;

   localparam int unsigned P_NONE  = 0;
   localparam int unsigned P_ODD   = 1;
   localparam int unsigned P_EVE   = 2;
   localparam int unsigned P_MARK  = 3;
   localparam int unsigned P_SPACE = 4;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      START    = 3'd1,
      DATA     = 3'd2,
      PARITY   = 3'd3,
      STOP     = 3'd4,
      DELIVER  = 3'd5,
      BRK_WAIT = 3'd6
   } state_t;

   // Clocks per oversample tick, never below 1.
   function automatic int unsigned calc_div(input int unsigned clk_freq,
                                            input int unsigned baud_rate,
                                            input int unsigned oversample);
      int unsigned div;
      div = clk_freq / (baud_rate * oversample);
      return (div == 0) ? 1 : div;
   endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Free-running oversample tick: a one-cycle pulse every DIV clocks.
module uart_os_tick
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned BAUD_RATE  = 9600,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic iClk,
   input  logic iRst,
   output logic oTick
);

   localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q;

   always_ff @(posedge iClk) begin
      if (iRst) begin
         cnt_q <= '0;
      end else if (cnt_q == CW'(DIV - 1)) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign oTick = (cnt_q == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with mid-bit sampling, parity/framing/overrun/break
// detection and a ready/valid output holding one word.
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ    = 50_000_000,
   parameter int unsigned BAUD_RATE   = 9600,
   parameter int unsigned OVERSAMPLE  = 16,
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned PARITY_TYPE = 0,
   parameter int unsigned STOP_BITS   = 1
) (
   input  logic                 iClk,
   input  logic                 iRst,
   input  logic                 iRx,
   input  logic                 iReady,
   output logic [DATA_BITS-1:0] oData,
   output logic                 oValid,
   output logic                 oPar_err,
   output logic                 oFrame_err,
   output logic                 oOverrun,
   output logic                 oBreak,
   output logic                 oBusy
);

   localparam int unsigned OSW = $clog2(OVERSAMPLE);
   localparam int unsigned BW  = $clog2(DATA_BITS);

   logic                 os_tick;
   logic                 rx_meta_q, rx_s;
   state_t               state_q, state_d;
   logic [OSW-1:0]       os_cnt_q, os_cnt_d;
   logic [BW-1:0]        bit_idx_q, bit_idx_d;
   logic                 stop_idx_q, stop_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_err_q, par_err_d, frm_err_q, frm_err_d;
   logic                 par_bit_q, par_bit_d, stop0_q, stop0_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d, pe_out_q, pe_out_d, fe_out_q, fe_out_d;
   logic                 overrun_q, overrun_d, break_q, break_d;
   logic                 exp_par, is_brk, at_mid, at_last;

   uart_os_tick #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE),
      .OVERSAMPLE(OVERSAMPLE)
   ) u_tick (
      .iClk (iClk),
      .iRst (iRst),
      .oTick(os_tick)
   );

   always_comb begin
      exp_par = 1'b0;
      case (PARITY_TYPE)
         P_ODD:   exp_par = ~^shift_q;
         P_EVE:   exp_par = ^shift_q;
         P_MARK:  exp_par = 1'b1;
         default: exp_par = 1'b0;
      endcase
   end

   assign at_mid  = os_tick && (os_cnt_q == OSW'(OVERSAMPLE / 2 - 1));
   assign at_last = os_tick && (os_cnt_q == OSW'(OVERSAMPLE - 1));
   assign is_brk  = (shift_q == '0) && ((PARITY_TYPE == P_NONE) || !par_bit_q) && !stop0_q;

   always_comb begin
      state_d    = state_q;
      os_cnt_d   = os_cnt_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      shift_d    = shift_q;
      par_err_d  = par_err_q;
      frm_err_d  = frm_err_q;
      par_bit_d  = par_bit_q;
      stop0_d    = stop0_q;
      data_d     = data_q;
      valid_d    = valid_q;
      pe_out_d   = pe_out_q;
      fe_out_d   = fe_out_q;
      overrun_d  = 1'b0;
      break_d    = 1'b0;

      if (valid_q && iReady) valid_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d  = START;
               os_cnt_d = '0;
            end
         end
         START: begin
            if (at_mid) begin
               os_cnt_d   = '0;
               bit_idx_d  = '0;
               stop_idx_d = 1'b0;
               par_err_d  = 1'b0;
               frm_err_d  = 1'b0;
               par_bit_d  = 1'b0;
               state_d    = rx_s ? IDLE : DATA;
            end else if (os_tick) begin
               os_cnt_d = os_cnt_q + OSW'(1);
            end
         end
         DATA: begin
            if (at_last) begin
               os_cnt_d           = '0;
               shift_d[bit_idx_q] = rx_s;
               if (bit_idx_q == BW'(DATA_BITS - 1)) begin
                  state_d = (PARITY_TYPE != P_NONE) ? PARITY : STOP;
               end else begin
                  bit_idx_d = bit_idx_q + BW'(1);
               end
            end else if (os_tick) begin
               os_cnt_d = os_cnt_q + OSW'(1);
            end
         end
         PARITY: begin
            if (at_last) begin
               os_cnt_d  = '0;
               par_bit_d = rx_s;
               par_err_d = (rx_s != exp_par);
               state_d   = STOP;
            end else if (os_tick) begin
               os_cnt_d = os_cnt_q + OSW'(1);
            end
         end
         STOP: begin
            if (at_last) begin
               os_cnt_d = '0;
               if (!rx_s) frm_err_d = 1'b1;
               if (!stop_idx_q) stop0_d = rx_s;
               if (stop_idx_q == 1'(STOP_BITS - 1)) state_d = DELIVER;
               else stop_idx_d = 1'b1;
            end else if (os_tick) begin
               os_cnt_d = os_cnt_q + OSW'(1);
            end
         end
         DELIVER: begin
            os_cnt_d = '0;
            state_d  = IDLE;
            if (is_brk) begin
               break_d = 1'b1;
               state_d = BRK_WAIT;
            end else if (!valid_q || iReady) begin
               data_d   = shift_q;
               pe_out_d = par_err_q;
               fe_out_d = frm_err_q;
               valid_d  = 1'b1;
            end else begin
               overrun_d = 1'b1;
            end
         end
         BRK_WAIT: begin
            // Any low sample restarts the one-bit idle requirement.
            if (!rx_s) begin
               os_cnt_d = '0;
            end else if (at_last) begin
               os_cnt_d = '0;
               state_d  = IDLE;
            end else if (os_tick) begin
               os_cnt_d = os_cnt_q + OSW'(1);
            end
         end
         default: begin
            state_d  = IDLE;
            os_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         rx_meta_q  <= 1'b1;
         rx_s       <= 1'b1;
         state_q    <= IDLE;
         os_cnt_q   <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         shift_q    <= '0;
         par_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
         par_bit_q  <= 1'b0;
         stop0_q    <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         pe_out_q   <= 1'b0;
         fe_out_q   <= 1'b0;
         overrun_q  <= 1'b0;
         break_q    <= 1'b0;
      end else begin
         rx_meta_q  <= iRx;
         rx_s       <= rx_meta_q;
         state_q    <= state_d;
         os_cnt_q   <= os_cnt_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         shift_q    <= shift_d;
         par_err_q  <= par_err_d;
         frm_err_q  <= frm_err_d;
         par_bit_q  <= par_bit_d;
         stop0_q    <= stop0_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         pe_out_q   <= pe_out_d;
         fe_out_q   <= fe_out_d;
         overrun_q  <= overrun_d;
         break_q    <= break_d;
      end
   end

   assign oData      = data_q;
   assign oValid     = valid_q;
   assign oPar_err   = pe_out_q;
   assign oFrame_err = fe_out_q;
   assign oOverrun   = overrun_q;
   assign oBreak     = break_q;
   assign oBusy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8N1 and an 8E1 receiver driven by frames built
// bit by bit, checked against expectations derived from the frame contents.
module tb_uart_rx_os;

   localparam int BIT = 64;  // clocks per bit at DIV=4, OVERSAMPLE=16

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx_n = 1'b1, rx_e = 1'b1, rdy_n = 1'b1, rdy_e = 1'b1;
   logic [7:0] data_n, data_e;
   logic valid_n, pe_n, fe_n, ovr_n, brk_n, busy_n;
   logic valid_e, pe_e, fe_e, ovr_e, brk_e, busy_e;

   always #5 clk = ~clk;

   uart_rx_os #(.CLK_FREQ(6_400_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY_TYPE(0), .STOP_BITS(1)) dut_n (
      .iClk(clk), .iRst(rst), .iRx(rx_n), .iReady(rdy_n), .oData(data_n),
      .oValid(valid_n), .oPar_err(pe_n), .oFrame_err(fe_n), .oOverrun(ovr_n),
      .oBreak(brk_n), .oBusy(busy_n));

   uart_rx_os #(.CLK_FREQ(6_400_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY_TYPE(2), .STOP_BITS(1)) dut_e (
      .iClk(clk), .iRst(rst), .iRx(rx_e), .iReady(rdy_e), .oData(data_e),
      .oValid(valid_e), .oPar_err(pe_e), .oFrame_err(fe_e), .oOverrun(ovr_e),
      .oBreak(brk_e), .oBusy(busy_e));

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      int         cyc;
   } acc_t;

   typedef struct {
      bit         sel_e;
      logic [7:0] d;
      bit         par_bit;
      bit         stop_bad;
      logic [7:0] exp_d;
      bit         exp_pe;
      bit         exp_fe;
   } vec_t;

   acc_t q_n[$], q_e[$];
   int cyc = 0;
   int vcyc_n = 0, ovr_cnt_n = 0, brk_cnt_n = 0, brk_cnt_e = 0, hold_viol = 0;
   logic hold_p = 1'b0;
   logic [9:0] hold_v = '0;
   int n_pass = 0, n_total = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Transfers are observed on the negedge before the accepting clock edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (valid_n) vcyc_n++;
         if (valid_n && rdy_n) q_n.push_back('{data_n, pe_n, fe_n, cyc});
         if (valid_e && rdy_e) q_e.push_back('{data_e, pe_e, fe_e, cyc});
         if (ovr_n) ovr_cnt_n++;
         if (brk_n) brk_cnt_n++;
         if (brk_e) brk_cnt_e++;
         if (hold_p && valid_n && ({data_n, pe_n, fe_n} != hold_v)) hold_viol++;
         hold_p = valid_n && !rdy_n;
         hold_v = {data_n, pe_n, fe_n};
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   task automatic clocks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_rx(input bit sel_e, input logic v);
      if (sel_e) rx_e = v;
      else rx_n = v;
   endtask

   // Start, 8 data bits LSB first, even parity on the E line, one stop bit.
   // A bad stop bit is low across its midpoint and high for its last quarter.
   task automatic send_frame(input bit sel_e, input logic [7:0] d, input bit par_bit,
                             input bit stop_bad, input int gap, output int c0);
      set_rx(sel_e, 1'b0);
      c0 = cyc;
      clocks(BIT);
      for (int i = 0; i < 8; i++) begin
         set_rx(sel_e, d[i]);
         clocks(BIT);
      end
      if (sel_e) begin
         set_rx(sel_e, par_bit);
         clocks(BIT);
      end
      if (stop_bad) begin
         set_rx(sel_e, 1'b0);
         clocks(48);
         set_rx(sel_e, 1'b1);
         clocks(16);
      end else begin
         set_rx(sel_e, 1'b1);
         clocks(BIT);
      end
      clocks(gap);
   endtask

   // Stop-bit midpoint from the start edge, plus synchroniser, tick phase and
   // the delivery clock.
   task automatic check_word(input string name, input bit sel_e, input int c0,
                             input logic [7:0] exp_d, input bit exp_pe, input bit exp_fe);
      acc_t a;
      int mid;
      mid = (sel_e ? 10 : 9) * BIT + BIT / 2;
      chk({name, "_count"}, sel_e ? q_e.size() : q_n.size(), 1);
      if ((sel_e ? q_e.size() : q_n.size()) > 0) begin
         a = sel_e ? q_e.pop_front() : q_n.pop_front();
         chk({name, "_data"}, int'(a.d), int'(exp_d));
         chk({name, "_par_err"}, int'(a.pe), int'(exp_pe));
         chk({name, "_frame_err"}, int'(a.fe), int'(exp_fe));
         chk({name, "_latency_ok"}, int'((a.cyc - c0 >= mid) && (a.cyc - c0 <= mid + 8)), 1);
      end
      q_n.delete();
      q_e.delete();
   endtask

   initial begin
      vec_t vecs[7];
      int c0, v0, o0, b0;
      logic [7:0] d;
      bit pb, sb, sel, exp_pe;

      vecs[0] = '{0, 8'hA5, 0, 0, 8'hA5, 0, 0};
      vecs[1] = '{1, 8'h3C, 1, 0, 8'h3C, 1, 0};
      vecs[2] = '{1, 8'h3C, 0, 0, 8'h3C, 0, 0};
      vecs[3] = '{0, 8'h81, 0, 1, 8'h81, 0, 1};
      vecs[4] = '{1, 8'h07, 1, 0, 8'h07, 0, 0};
      vecs[5] = '{1, 8'h07, 0, 0, 8'h07, 1, 0};
      vecs[6] = '{1, 8'hFF, 0, 1, 8'hFF, 0, 1};

      clocks(5);
      chk("reset_valid", int'(valid_n), 0);
      chk("reset_data", int'(data_n), 0);
      chk("reset_busy", int'(busy_n), 0);
      chk("reset_flags", int'({pe_n, fe_n, ovr_n, brk_n}), 0);
      rst = 1'b0;
      clocks(BIT);

      // Directed frames; the first also checks that oValid lasts one clock.
      for (int i = 0; i < 7; i++) begin
         v0 = vcyc_n;
         send_frame(vecs[i].sel_e, vecs[i].d, vecs[i].par_bit, vecs[i].stop_bad, 100, c0);
         if (i == 0) chk("a5_valid_cycles", vcyc_n - v0, 1);
         check_word($sformatf("vec%0d", i), vecs[i].sel_e, c0, vecs[i].exp_d,
                    vecs[i].exp_pe, vecs[i].exp_fe);
      end

      // Short low glitch is rejected at the start-bit midpoint.
      rx_n = 1'b0;
      clocks(20);
      rx_n = 1'b1;
      clocks(150);
      chk("glitch_no_word", q_n.size(), 0);
      chk("glitch_busy", int'(busy_n), 0);
      chk("glitch_no_break", brk_cnt_n, 0);

      // Backpressure: second frame overruns, first word is held.
      o0 = ovr_cnt_n;
      rdy_n = 1'b0;
      send_frame(0, 8'h11, 0, 0, 0, c0);
      send_frame(0, 8'h22, 0, 0, 100, c0);
      chk("ovr_pulses", ovr_cnt_n - o0, 1);
      chk("ovr_held_valid", int'(valid_n), 1);
      chk("ovr_held_data", int'(data_n), 8'h11);
      chk("ovr_hold_stable", hold_viol, 0);
      chk("ovr_none_taken", q_n.size(), 0);
      rdy_n = 1'b1;
      clocks(1);
      chk("ovr_valid_drop", int'(valid_n), 0);
      chk("ovr_taken", q_n.size(), 1);
      if (q_n.size() > 0) chk("ovr_taken_data", int'(q_n[0].d), 8'h11);
      q_n.delete();
      clocks(BIT);

      // Break: line low for 15 bit times.
      b0 = brk_cnt_n;
      rx_n = 1'b0;
      clocks(15 * BIT);
      chk("brk_busy_low", int'(busy_n), 1);
      rx_n = 1'b1;
      clocks(2 * BIT);
      chk("brk_pulses", brk_cnt_n - b0, 1);
      chk("brk_no_word", q_n.size(), 0);
      chk("brk_idle", int'(busy_n), 0);
      send_frame(0, 8'h5A, 0, 0, 100, c0);
      check_word("post_brk", 0, c0, 8'h5A, 0, 0);

      // Reset mid-frame with a word held on the output.
      rdy_n = 1'b0;
      send_frame(0, 8'h33, 0, 0, 20, c0);
      chk("rst_pre_valid", int'(valid_n), 1);
      rx_n = 1'b0;
      clocks(3 * BIT);
      rst = 1'b1;
      rx_n = 1'b1;
      clocks(3);
      chk("rst_mid_valid", int'(valid_n), 0);
      chk("rst_mid_data", int'(data_n), 0);
      chk("rst_mid_busy", int'(busy_n), 0);
      chk("rst_mid_flags", int'({pe_n, fe_n, ovr_n, brk_n}), 0);
      rst = 1'b0;
      rdy_n = 1'b1;
      q_n.delete();
      clocks(BIT);
      send_frame(0, 8'h7E, 0, 0, 100, c0);
      check_word("post_rst", 0, c0, 8'h7E, 0, 0);

      // Random frames against the frame-level model.
      for (int i = 0; i < 16; i++) begin
         sel = i[0];
         d = 8'($urandom_range(1, 255));
         pb = 1'($urandom_range(0, 1));
         sb = ($urandom_range(0, 3) == 0);
         exp_pe = sel && (pb != ^d);
         send_frame(sel, d, pb, sb, 100, c0);
         check_word($sformatf("rnd%0d", i), sel, c0, d, exp_pe, sb);
      end
      chk("rnd_no_break", brk_cnt_e, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule
